scalar_tuple_collect: RTL
=========================

Name: scalar_tuple_collect

Overview:
Receive end of the scalar-tuple field stream. Accepts one (index, value) field per valid/ready beat, truncates each value to its field width and assembles the tuple out1..out8, out10. Presents the assembled tuple with a valid/ready handshake once every field has arrived. Sits between a field serializer upstream and any consumer of the parallel tuple outputs downstream.

Parameters:
IDX_W, 4, width of in_idx.
DATA_W, 4, width of in_data; must be >= widest field (4).
TIMEOUT_CYCLES, 16, idle cycles in COLLECT before abort; 0 disables timeout.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  field beat valid.
in_ready  output  1  block can accept a field beat.
in_idx  input  IDX_W  field index: 0..8 maps to out1,out2,out3,out4,out5,out6,out7,out8,out10.
in_data  input  DATA_W  field value; upper bits beyond field width are discarded.
tuple_valid  output  1  complete tuple held on outputs.
tuple_ready  input  1  consumer takes tuple.
out1  output  3  field 0.
out2  output  4  field 1.
out3  output  4  field 2.
out4  output  4  field 3.
out5  output  3  field 4.
out6  output  3  field 5.
out7  output  2  field 6.
out8  output  2  field 7.
out10  output  3  field 8.
err_dup  output  1  one-cycle pulse: field index already filled in current tuple.
err_idx  output  1  one-cycle pulse: in_idx > 8.
err_timeout  output  1  one-cycle pulse: COLLECT aborted by timeout.

Behaviour:
- Reset (reset=1 at clock edge): state IDLE, fill mask 9'b0, timeout counter 0, all out* = 0 (see Optional Feature), tuple_valid=0, in_ready=1, err_* = 0. Overrides any in-flight beat or held tuple.
- Beat accepted when in_valid & in_ready at clock edge. in_ready = 1 in IDLE and COLLECT, 0 in HOLD.
- States: IDLE (mask empty), COLLECT (mask partial), HOLD (mask full, tuple_valid=1).
- Accepted valid beat, idx 0..8, mask bit clear: field register <= in_data[width-1:0]; mask bit set; IDLE->COLLECT; counter cleared.
- Accepted beat with mask bit already set: field unchanged, err_dup pulses next cycle, state unchanged, beat consumed.
- Accepted beat with idx > 8: nothing stored, err_idx pulses, beat consumed.
- Beat that sets the last mask bit: next cycle state HOLD, tuple_valid=1 (latency 1 cycle from final accepting edge). Fields arriving in any order.
- HOLD: outputs stable; in_ready=0. On tuple_valid & tuple_ready edge: mask cleared, state IDLE, fields reset to their reset values, tuple_valid=0.
- Timeout: in COLLECT, counter increments each cycle without an accepted beat; when counter reaches TIMEOUT_CYCLES-1 and no beat accepted that edge, err_timeout pulses, mask cleared, fields reset, state IDLE. Counter does not run in IDLE/HOLD.
- err_* registered, high exactly one cycle per event; at most one of err_dup/err_idx per beat.
- Out-of-width in_data bits silently dropped (e.g. out7 gets in_data[1:0]).

Optional Feature:
SCALAR_TUPLE_DEFAULTS_EN: defined -> field reset/clear values are out1=3'd7, out2=4'd8, out3=4'd9, out4=4'd10, out5=3'd7, out6=3'd6, out7=2'd3, out8=2'd3, out10=3'd5 (applied on reset, after handshake, and after timeout). Undefined -> all fields clear to 0. Handshake and mask behaviour identical either way.

Test Plan:
- Reset, then send idx 0..8 with data 7,8,9,10,7,6,3,3,5 back-to-back -> tuple_valid high cycle after 9th beat; outputs equal those values; in_ready=0 while tuple_ready=0.
- Send fields in order 8,3,0,7,1,6,2,5,4 with in_data=4'hF each -> out1=7,out2..out4=15,out5=7,out6=7,out7=3,out8=3,out10=7; tuple_valid asserted once.
- Send idx 2 data 5 then idx 2 data 1 -> err_dup pulses one cycle, out3 stays 5; idx 12 -> err_idx pulses, mask unchanged.
- Send 3 fields then hold in_valid=0 for 16 cycles (TIMEOUT_CYCLES=16) -> err_timeout one pulse, state IDLE, outputs at clear values, next full tuple completes normally.
- Complete tuple, hold tuple_ready=0 for 5 cycles then 1 -> outputs stable 5 cycles; after handshake tuple_valid=0, in_ready=1; assert reset mid-COLLECT -> mask clear, no tuple_valid.
- Build with and without SCALAR_TUPLE_DEFAULTS_EN, after reset -> outputs 7,8,9,10,7,6,3,3,5 vs all zero.

Source files
------------

// File: rtl/scalar_tuple_collect.sv
// scalar_tuple_collect: gathers (in_idx, in_data) field beats into tuple out1..out8,out10 (widths 3,4,4,4,3,3,2,2,3), presents it on tuple_valid/tuple_ready, flags err_dup/err_idx/err_timeout; define SCALAR_TUPLE_DEFAULTS_EN for nonzero field clear values
module scalar_tuple_collect #(
  parameter int IDX_W = 4,
  parameter int DATA_W = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_data,
  output logic              tuple_valid,
  input  logic              tuple_ready,
  output logic [2:0]        out1,
  output logic [3:0]        out2,
  output logic [3:0]        out3,
  output logic [3:0]        out4,
  output logic [2:0]        out5,
  output logic [2:0]        out6,
  output logic [1:0]        out7,
  output logic [1:0]        out8,
  output logic [2:0]        out10,
  output logic              err_dup,
  output logic              err_idx,
  output logic              err_timeout
);
  localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef SCALAR_TUPLE_DEFAULTS_EN
  localparam logic [2:0] D1 = 3'd7;
  localparam logic [3:0] D2 = 4'd8;
  localparam logic [3:0] D3 = 4'd9;
  localparam logic [3:0] D4 = 4'd10;
  localparam logic [2:0] D5 = 3'd7;
  localparam logic [2:0] D6 = 3'd6;
  localparam logic [1:0] D7 = 2'd3;
  localparam logic [1:0] D8 = 2'd3;
  localparam logic [2:0] D10 = 3'd5;
`else
  localparam logic [2:0] D1 = 3'd0;
  localparam logic [3:0] D2 = 4'd0;
  localparam logic [3:0] D3 = 4'd0;
  localparam logic [3:0] D4 = 4'd0;
  localparam logic [2:0] D5 = 3'd0;
  localparam logic [2:0] D6 = 3'd0;
  localparam logic [1:0] D7 = 2'd0;
  localparam logic [1:0] D8 = 2'd0;
  localparam logic [2:0] D10 = 3'd0;
`endif
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t           state;
  logic [8:0]       mask, sel, nmask;
  logic [CNT_W-1:0] cnt;
  logic             acc, bad, dup, wr, tmo, clr;
  assign in_ready = state != HOLD;
  assign tuple_valid = state == HOLD;
  always_comb begin
    acc = in_valid && in_ready;
    bad = in_idx > IDX_W'(8);
    sel = bad ? 9'd0 : 9'd1 << in_idx;
    dup = |(sel & mask);
    wr = acc && !bad && !dup;
    nmask = mask | sel;
    tmo = TIMEOUT_CYCLES != 0 && state == COLLECT && !acc && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    clr = tmo || (state == HOLD && tuple_ready);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      mask <= '0;
      cnt <= '0;
      err_dup <= 1'b0;
      err_idx <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_dup <= acc && !bad && dup;
      err_idx <= acc && bad;
      err_timeout <= tmo;
      if (clr) begin
        state <= IDLE;
        mask <= '0;
        cnt <= '0;
      end else if (acc) begin
        cnt <= '0;
        if (wr) begin
          mask <= nmask;
          state <= &nmask ? HOLD : COLLECT;
        end
      end else if (state == COLLECT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      out1 <= D1;
      out2 <= D2;
      out3 <= D3;
      out4 <= D4;
      out5 <= D5;
      out6 <= D6;
      out7 <= D7;
      out8 <= D8;
      out10 <= D10;
    end else if (wr) begin
      if (sel[0]) out1 <= in_data[2:0];
      if (sel[1]) out2 <= in_data[3:0];
      if (sel[2]) out3 <= in_data[3:0];
      if (sel[3]) out4 <= in_data[3:0];
      if (sel[4]) out5 <= in_data[2:0];
      if (sel[5]) out6 <= in_data[2:0];
      if (sel[6]) out7 <= in_data[1:0];
      if (sel[7]) out8 <= in_data[1:0];
      if (sel[8]) out10 <= in_data[2:0];
    end
  end
endmodule
